// File: rtl/mulu_seq_x3y3_pkg.sv
// rtl/mulu_seq_x3y3_pkg.sv - shared widths, FSM encoding and counter sizing for mulu_seq_x3y3
// Contents: operand/product widths, iteration counter width, FSM state type.
// Used by both the unsigned build and the MULS_SIGNED_EN build.
package mulu_seq_x3y3_pkg;

  localparam int X_WIDTH = 3;
  localparam int Y_WIDTH = 3;
  localparam int P_WIDTH = X_WIDTH + Y_WIDTH;

  // Counter counts 0..Y_WIDTH-1; keep at least one bit for degenerate widths.
  localparam int CNT_WIDTH = (Y_WIDTH > 1) ? $clog2(Y_WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mulu_seq_x3y3_if.sv
// rtl/mulu_seq_x3y3_if.sv - request/result bundle between a requester and mulu_seq_x3y3
// Signals: start, x, y (requester -> multiplier); p, rdy, busy (multiplier -> requester);
// s (product sign, multiplier -> requester) exists only when MULS_SIGNED_EN is defined.
// Modports: master = requester side, slave = multiplier side.
interface mulu_seq_x3y3_if;
  import mulu_seq_x3y3_pkg::*;

  logic               start;
  logic [X_WIDTH-1:0] x;
  logic [Y_WIDTH-1:0] y;
  logic [P_WIDTH-1:0] p;
  logic               rdy;
  logic               busy;

`ifdef MULS_SIGNED_EN
  logic               s;

  modport master (output start, x, y, input p, s, rdy, busy);
  modport slave  (input start, x, y, output p, s, rdy, busy);
`else
  modport master (output start, x, y, input p, rdy, busy);
  modport slave  (input start, x, y, output p, rdy, busy);
`endif

endinterface

// File: rtl/mulu_addshift_step.sv
// rtl/mulu_addshift_step.sv - one combinational shift-and-add iteration
// Inputs : acc, mcand (P_WIDTH), mplier (Y_WIDTH)
// Outputs: acc_next, mcand_next, mplier_next
// Holds no state; the parent owns the registers.
module mulu_addshift_step
  import mulu_seq_x3y3_pkg::*;
(
  input  logic [P_WIDTH-1:0] acc,
  input  logic [P_WIDTH-1:0] mcand,
  input  logic [Y_WIDTH-1:0] mplier,
  output logic [P_WIDTH-1:0] acc_next,
  output logic [P_WIDTH-1:0] mcand_next,
  output logic [Y_WIDTH-1:0] mplier_next
);

  // acc cannot overflow: the largest product fits P_WIDTH bits.
  assign acc_next    = mplier[0] ? (acc + mcand) : acc;
  assign mcand_next  = mcand << 1;
  assign mplier_next = mplier >> 1;

endmodule

// File: rtl/mulu_seq_x3y3.sv
// rtl/mulu_seq_x3y3.sv - sequential shift-and-add multiplier, one partial product per clock
// Ports: clk (rising edge), rst (async, active-low), bus (mulu_seq_x3y3_if.slave:
//   start/x/y in, p/rdy/busy out, s out with MULS_SIGNED_EN).
// Option: MULS_SIGNED_EN -> two's complement operands, p = |x*y|, s = sign (0 when p==0).
module mulu_seq_x3y3
  import mulu_seq_x3y3_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  mulu_seq_x3y3_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(Y_WIDTH - 1);

  state_t             state_q;
  state_t             state_d;
  logic [P_WIDTH-1:0] acc_q;
  logic [P_WIDTH-1:0] mcand_q;
  logic [Y_WIDTH-1:0] mplier_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [P_WIDTH-1:0] p_q;
  logic               rdy_q;
  logic               busy_q;

  logic [P_WIDTH-1:0] acc_n;
  logic [P_WIDTH-1:0] mcand_n;
  logic [Y_WIDTH-1:0] mplier_n;

  logic               load;
  logic               step;
  logic               finish;

  logic [X_WIDTH-1:0] x_mag;
  logic [Y_WIDTH-1:0] y_mag;

`ifdef MULS_SIGNED_EN
  logic sign_q;
  logic s_q;

  // |-2^(W-1)| wraps to 2^(W-1), which is still correct read as unsigned.
  assign x_mag = bus.x[X_WIDTH-1] ? (~bus.x + X_WIDTH'(1)) : bus.x;
  assign y_mag = bus.y[Y_WIDTH-1] ? (~bus.y + Y_WIDTH'(1)) : bus.y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_q <= 1'b0;
      s_q    <= 1'b0;
    end else if (load) begin
      sign_q <= bus.x[X_WIDTH-1] ^ bus.y[Y_WIDTH-1];
    end else if (finish) begin
      // A zero product is never reported as negative.
      s_q <= sign_q & (acc_n != '0);
    end
  end

  assign bus.s = s_q;
`else
  assign x_mag = bus.x;
  assign y_mag = bus.y;
`endif

  mulu_addshift_step u_step (
    .acc         (acc_q),
    .mcand       (mcand_q),
    .mplier      (mplier_q),
    .acc_next    (acc_n),
    .mcand_next  (mcand_n),
    .mplier_next (mplier_n)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST_CNT) state_d = ST_DONE;
      ST_DONE: if (bus.start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control decode; start during RUN is simply not looked at.
  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: load = bus.start;
      ST_RUN: begin
        step   = 1'b1;
        finish = (cnt_q == LAST_CNT);
      end
      default: begin
        load = 1'b0;
      end
    endcase
  end

  // Datapath. p is only written on the final iteration, so it stays
  // stable through a following run until the new product is ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else if (load) begin
      acc_q    <= '0;
      mcand_q  <= {{(P_WIDTH-X_WIDTH){1'b0}}, x_mag};
      mplier_q <= y_mag;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b1;
    end else if (step) begin
      acc_q    <= acc_n;
      mcand_q  <= mcand_n;
      mplier_q <= mplier_n;
      cnt_q    <= cnt_q + CNT_WIDTH'(1);
      if (finish) begin
        p_q    <= acc_n;
        rdy_q  <= 1'b1;
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.p    = p_q;
  assign bus.rdy  = rdy_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_mulu_seq_x3y3.sv
// tb/tb_mulu_seq_x3y3.sv - directed and table-driven bench for mulu_seq_x3y3 (both MULS_SIGNED_EN settings)
module tb_mulu_seq_x3y3;
  import mulu_seq_x3y3_pkg::*;

  typedef struct {
    logic [2:0] x;
    logic [2:0] y;
    logic [5:0] p;
    logic       s;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[8];

`ifdef MULS_SIGNED_EN
  localparam logic [5:0] BASIC_P = 6'd6;   // (-3)*(-2)
  localparam logic       BASIC_S = 1'b0;
  localparam logic [5:0] B2B_P   = 6'd6;   // 2*(-3)
  localparam logic       B2B_S   = 1'b1;
`else
  localparam logic [5:0] BASIC_P = 6'd30;  // 5*6
  localparam logic       BASIC_S = 1'b0;
  localparam logic [5:0] B2B_P   = 6'd10;  // 2*5
  localparam logic       B2B_S   = 1'b0;
`endif

  always #5 clk = ~clk;

  mulu_seq_x3y3_if bus ();

  mulu_seq_x3y3 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input logic exp);
`ifdef MULS_SIGNED_EN
    chk(name, {31'd0, bus.s}, {31'd0, exp});
`else
    if (exp !== 1'b0) chk(name, 32'd1, 32'd0);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic void ref_mul(input logic [2:0] xv, input logic [2:0] yv,
                                  output logic [5:0] ep, output logic es);
    int xs;
    int ys;
    int prod;
`ifdef MULS_SIGNED_EN
    xs = $signed(xv);
    ys = $signed(yv);
`else
    xs = int'(xv);
    ys = int'(yv);
`endif
    prod = xs * ys;
    ep   = 6'((prod < 0) ? -prod : prod);
    es   = (prod < 0);
  endfunction

  // Single start pulse, then checks busy/rdy over the three RUN edges and the result.
  task automatic run_op(input logic [2:0] xv, input logic [2:0] yv,
                        input logic [5:0] ep, input logic es, input string tag);
    bus.x     = xv;
    bus.y     = yv;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.x     = ~xv;  // operands must already be captured
    bus.y     = ~yv;
    chk({tag, " busy@1"}, {31'd0, bus.busy}, 32'd1);
    chk({tag, " rdy@1"},  {31'd0, bus.rdy},  32'd0);
    tick();
    tick();
    chk({tag, " busy@3"}, {31'd0, bus.busy}, 32'd1);
    chk({tag, " rdy@3"},  {31'd0, bus.rdy},  32'd0);
    tick();
    chk({tag, " rdy"},  {31'd0, bus.rdy},  32'd1);
    chk({tag, " busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, " p"},    {26'd0, bus.p},    {26'd0, ep});
    chk_s({tag, " s"}, es);
  endtask

  initial begin
    logic [5:0] ep;
    logic       es;

`ifdef MULS_SIGNED_EN
    vecs[0] = '{x: 3'b101, y: 3'd2,   p: 6'd6,  s: 1'b1};  // -3*2
    vecs[1] = '{x: 3'b100, y: 3'b100, p: 6'd16, s: 1'b0};  // -4*-4
    vecs[2] = '{x: 3'd0,   y: 3'b111, p: 6'd0,  s: 1'b0};  // 0*-1
    vecs[3] = '{x: 3'd3,   y: 3'd3,   p: 6'd9,  s: 1'b0};
    vecs[4] = '{x: 3'b111, y: 3'b111, p: 6'd1,  s: 1'b0};  // -1*-1
    vecs[5] = '{x: 3'd3,   y: 3'b100, p: 6'd12, s: 1'b1};  // 3*-4
    vecs[6] = '{x: 3'b100, y: 3'd3,   p: 6'd12, s: 1'b1};  // -4*3
    vecs[7] = '{x: 3'd2,   y: 3'b101, p: 6'd6,  s: 1'b1};  // 2*-3
`else
    vecs[0] = '{x: 3'd5, y: 3'd6, p: 6'd30, s: 1'b0};
    vecs[1] = '{x: 3'd7, y: 3'd7, p: 6'd49, s: 1'b0};
    vecs[2] = '{x: 3'd0, y: 3'd7, p: 6'd0,  s: 1'b0};
    vecs[3] = '{x: 3'd7, y: 3'd1, p: 6'd7,  s: 1'b0};
    vecs[4] = '{x: 3'd3, y: 3'd3, p: 6'd9,  s: 1'b0};
    vecs[5] = '{x: 3'd1, y: 3'd1, p: 6'd1,  s: 1'b0};
    vecs[6] = '{x: 3'd2, y: 3'd5, p: 6'd10, s: 1'b0};
    vecs[7] = '{x: 3'd6, y: 3'd4, p: 6'd24, s: 1'b0};
`endif

    rst       = 1'b0;
    bus.start = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    tick();
    tick();
    chk("reset p",    {26'd0, bus.p},    32'd0);
    chk("reset rdy",  {31'd0, bus.rdy},  32'd0);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk_s("reset s", 1'b0);
    rst = 1'b1;
    tick();
    chk("idle busy", {31'd0, bus.busy}, 32'd0);

    // Basic run, then result held through idle cycles with wiggling operands.
    run_op(3'd5, 3'd6, BASIC_P, BASIC_S, "basic");
    for (int i = 0; i < 10; i++) begin
      bus.x = 3'(i);
      bus.y = 3'(i + 3);
      tick();
    end
    chk("hold rdy",  {31'd0, bus.rdy},  32'd1);
    chk("hold p",    {26'd0, bus.p},    {26'd0, BASIC_P});
    chk("hold busy", {31'd0, bus.busy}, 32'd0);

    // Start while busy: second request ignored.
    bus.x     = 3'd3;
    bus.y     = 3'd3;
    bus.start = 1'b1;
    tick();
    bus.x = 3'd7;
    bus.y = 3'd7;
    tick();
    bus.start = 1'b0;
    chk("swb busy", {31'd0, bus.busy}, 32'd1);
    tick();
    tick();
    chk("swb rdy", {31'd0, bus.rdy}, 32'd1);
    chk("swb p",   {26'd0, bus.p},   32'd9);
    chk_s("swb s", 1'b0);
    tick();
    chk("swb no restart", {31'd0, bus.busy}, 32'd0);

    // Back-to-back: start held, rdy every fourth edge, p stable across runs.
    bus.x     = 3'd2;
    bus.y     = 3'd5;
    bus.start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("b2b rdy %0d", i), {31'd0, bus.rdy}, {31'd0, (i % 4) == 3});
      if (i < 3) begin
        chk($sformatf("b2b old p %0d", i), {26'd0, bus.p}, 32'd9);
      end else begin
        chk($sformatf("b2b p %0d", i), {26'd0, bus.p}, {26'd0, B2B_P});
      end
      if ((i % 4) == 3) chk_s($sformatf("b2b s %0d", i), B2B_S);
    end
    bus.start = 1'b0;
    tick();

    // Asynchronous reset in the middle of a run, start still held.
    bus.x     = 3'd7;
    bus.y     = 3'd3;
    bus.start = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("mid rst p",    {26'd0, bus.p},    32'd0);
    chk("mid rst rdy",  {31'd0, bus.rdy},  32'd0);
    chk("mid rst busy", {31'd0, bus.busy}, 32'd0);
    chk_s("mid rst s", 1'b0);
    tick();
    chk("in rst busy", {31'd0, bus.busy}, 32'd0);
    bus.start = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    chk("post rst busy", {31'd0, bus.busy}, 32'd0);
    chk("post rst rdy",  {31'd0, bus.rdy},  32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].p, vecs[i].s, $sformatf("vec%0d", i));
    end

    for (int xi = 0; xi < 8; xi++) begin
      for (int yi = 0; yi < 8; yi++) begin
        ref_mul(3'(xi), 3'(yi), ep, es);
        run_op(3'(xi), 3'(yi), ep, es, $sformatf("sweep x%0d y%0d", xi, yi));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
